// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, default shift table and FSM state type for fir_seq_ctrl
package fir_pkg;
  localparam int NTAPS = 5;
  localparam int DW = 8;
  localparam int OW = 10;
  localparam int AW = 11;
  localparam logic [NTAPS-1:0][2:0] DEF_SHIFT = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
endpackage

// File: rtl/fir_tap_line.sv
// fir_tap_line: one channel's sample history; taps[0] is the newest entry
// ports: clk, rst (sync clear), shift_en, din (sample shifted in), taps (history)
module fir_tap_line #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic [DW-1:0] din,
  output logic [DEPTH-1:0][DW-1:0] taps
);
  always_ff @(posedge clk)
    if (rst) taps <= '0;
    else if (shift_en) taps <= {taps[DEPTH-2:0], din};
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: two-channel sequential FIR with per-tap shift coefficients and round-robin arbitration
// ports: in_valid/x0/x1/in_ready sample input, cfg_we/cfg_tap/cfg_shift coefficient write,
//        out_valid/out_ready/out_ch/dataout result output, busy when not idle
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS = fir_pkg::NTAPS,
  parameter int DW = fir_pkg::DW,
  parameter int OW = fir_pkg::OW
) (
  input  logic clk,
  input  logic rst,
  input  logic [1:0] in_valid,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  output logic [1:0] in_ready,
  input  logic cfg_we,
  input  logic [2:0] cfg_tap,
  input  logic [2:0] cfg_shift,
  output logic out_valid,
  input  logic out_ready,
  output logic out_ch,
  output logic [OW-1:0] dataout,
  output logic busy
);
  localparam int KW = $clog2(NTAPS);
  localparam int HW = $clog2(NTAPS-1);
  state_t state, next;
  logic [KW-1:0] k;
  logic [AW-1:0] acc;
  logic [DW-1:0] smp, tap_val;
  logic ch, last_grant, grant, accept, shift_en;
  logic [NTAPS-1:0][2:0] shifts;
  logic [NTAPS-2:0][DW-1:0] h0, h1, hsel;
  assign grant = &in_valid ? ~last_grant : in_valid[1];
  assign accept = state == IDLE && |in_valid;
  assign shift_en = state == ACC && k == KW'(NTAPS-1);
  assign hsel = ch ? h1 : h0;
  assign tap_val = k == '0 ? smp : hsel[HW'(k - 1'b1)];
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
  assign out_ch = ch;
  assign dataout = |acc[AW-1:OW] ? '1 : acc[OW-1:0];
  always_comb begin
    in_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    next = state == IDLE ? (accept ? ACC : IDLE) :
           state == ACC ? (shift_en ? OUT : ACC) :
           (out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_ff @(posedge clk)
    if (rst) begin
      k <= '0;
      acc <= '0;
      smp <= '0;
      ch <= 1'b0;
      last_grant <= 1'b1;
      shifts <= DEF_SHIFT;
    end else begin
      if (state == IDLE && cfg_we && int'(cfg_tap) < NTAPS) shifts[cfg_tap] <= cfg_shift;
      if (accept) begin
        smp <= grant ? x1 : x0;
        ch <= grant;
        last_grant <= grant;
        acc <= '0;
        k <= '0;
      end else if (state == ACC) begin
        acc <= acc + AW'(tap_val >> shifts[k]);
        k <= k + 1'b1;
      end
    end
  fir_tap_line #(.DW(DW), .DEPTH(NTAPS-1)) u_tl0 (
    .clk(clk), .rst(rst), .shift_en(shift_en & ~ch), .din(smp), .taps(h0)
  );
  fir_tap_line #(.DW(DW), .DEPTH(NTAPS-1)) u_tl1 (
    .clk(clk), .rst(rst), .shift_en(shift_en & ch), .din(smp), .taps(h1)
  );
endmodule
